stopwatch_ctrl: RTL and testbench

//  Front-panel controller that sequences the stopwatch digit counter.
//  - Synchronises and debounces three push-buttons: start/stop, lap, clear.
//  - Runs the run/pause/lap/clear state machine and drives the counter's start_stop level and a clear pulse.
//  - Muxes either the live counter digits or a frozen lap snapshot onto the 7-seg display path.
//  - Sits between the board buttons and the counter + display driver. Top level ties the counter's rst to (rst | clr).

---
 rtl/stopwatch_ctrl.sv | 81 ++++++++
 tb/tb_stopwatch_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounces panel buttons, runs the run/pause/lap/clear FSM and muxes live or lap digits to the display
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic [3:0] d3_in,
  input  logic [3:0] d2_in,
  input  logic [3:0] d1_in,
  input  logic [3:0] d0_in,
  output logic       go,
  output logic       clr,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, PAUSE = 2'd3} state_t;
  state_t state, nxt;
  logic [2:0] raw, s1, s2, db, db_d, ev;
  logic [DB_W-1:0] cnt [3];
  logic [15:0] lap_q;
  logic do_clr, cap;
  assign raw = {btn_clr, btn_lap, btn_ss};
  // bit 0 = start/stop, bit 1 = lap, bit 2 = clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      ev   <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_d <= db;
      ev   <= db & ~db_d;
      for (int i = 0; i < 3; i++)
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      clr   <= 1'b0;
      lap_q <= '0;
    end else begin
      state <= nxt;
      clr   <= do_clr;
      if (cap) lap_q <= {d3_in, d2_in, d1_in, d0_in};
    end
  end
  // priority clr > ss > lap; a clr that does not apply in this state falls through
  always_comb begin
    nxt    = state;
    do_clr = 1'b0;
    cap    = 1'b0;
    case (state)
      IDLE:  if (ev[2]) do_clr = 1'b1; else if (ev[0]) nxt = RUN;
      RUN:   if (ev[0]) nxt = PAUSE; else if (ev[1]) begin nxt = LAP; cap = 1'b1; end
      LAP:   if (ev[0]) nxt = PAUSE; else if (ev[1]) nxt = RUN;
      PAUSE: if (ev[2]) begin do_clr = 1'b1; nxt = IDLE; end else if (ev[0]) nxt = RUN;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    go               = (state == RUN) || (state == LAP);
    state_o          = state;
    {d3, d2, d1, d0} = (state == LAP) ? lap_q : {d3_in, d2_in, d1_in, d0_in};
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenario tasks with hand-computed expectations for stopwatch_ctrl
module tb_stopwatch_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] btn = '0;
  logic [15:0] din = '0;
  logic go, clr;
  logic [3:0] d3, d2, d1, d0;
  logic [1:0] state_o;
  int checks = 0, fails = 0;
  int clr_cnt = 0, clr_go = 0, run_seen = 0;

  stopwatch_ctrl #(.DB_CYCLES(4), .DB_W(25)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn[0]), .btn_lap(btn[1]), .btn_clr(btn[2]),
    .d3_in(din[15:12]), .d2_in(din[11:8]), .d1_in(din[7:4]), .d0_in(din[3:0]),
    .go(go), .clr(clr), .d3(d3), .d2(d2), .d1(d1), .d0(d0), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr) clr_cnt++;
    if (clr && go) clr_go++;
    if (state_o == 2'd1) run_seen = 1;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] b, input int hold);
    btn = b;
    cycles(hold);
    btn = '0;
    cycles(12);
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    btn = '0;
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic test_reset;
    din = 16'h4321;
    apply_reset();
    chk("reset_state", {14'd0, state_o}, 16'd0);
    chk("reset_go", {15'd0, go}, 16'd0);
    chk("reset_clr", {15'd0, clr}, 16'd0);
    chk("reset_disp_live", {d3, d2, d1, d0}, 16'h4321);
  endtask

  task automatic test_latency;
    apply_reset();
    btn = 3'b001;
    cycles(7);
    chk("lat_idle_after_edge6", {14'd0, state_o}, 16'd0);
    chk("lat_go_low_after_edge6", {15'd0, go}, 16'd0);
    cycles(1);
    chk("lat_run_after_edge7", {14'd0, state_o}, 16'd1);
    chk("lat_go_high", {15'd0, go}, 16'd1);
    cycles(2);
    btn = '0;
    cycles(15);
    chk("lat_release_no_change", {14'd0, state_o}, 16'd1);
  endtask

  task automatic test_glitch;
    apply_reset();
    btn = 3'b001; cycles(3);
    btn = '0;     cycles(1);
    btn = 3'b001; cycles(3);
    btn = '0;     cycles(12);
    chk("glitch_stays_idle", {14'd0, state_o}, 16'd0);
    press(3'b001, 6);
    chk("glitch_then_hold_run", {14'd0, state_o}, 16'd1);
  endtask

  task automatic test_lap;
    din = 16'h0127;
    press(3'b010, 8);
    chk("lap_state", {14'd0, state_o}, 16'd2);
    chk("lap_go_running", {15'd0, go}, 16'd1);
    din = 16'h0135;
    cycles(1);
    chk("lap_frozen", {d3, d2, d1, d0}, 16'h0127);
    press(3'b010, 8);
    chk("lap_back_run", {14'd0, state_o}, 16'd1);
    din = 16'h0142;
    cycles(1);
    chk("lap_tracks_live", {d3, d2, d1, d0}, 16'h0142);
  endtask

  task automatic test_clear;
    clr_cnt = 0;
    press(3'b100, 8);
    chk("clr_ignored_in_run", {14'd0, state_o}, 16'd1);
    chk("clr_no_pulse_in_run", clr_cnt[15:0], 16'd0);
    press(3'b001, 8);
    chk("pause_state", {14'd0, state_o}, 16'd3);
    chk("pause_go_low", {15'd0, go}, 16'd0);
    clr_cnt = 0;
    clr_go = 0;
    press(3'b100, 8);
    chk("clr_to_idle", {14'd0, state_o}, 16'd0);
    chk("clr_one_pulse", clr_cnt[15:0], 16'd1);
    chk("clr_go_low", {15'd0, go}, 16'd0);
    chk("clr_never_with_go", clr_go[15:0], 16'd0);
  endtask

  task automatic test_back_to_back;
    press(3'b001, 8);
    press(3'b001, 8);
    chk("b2b_in_pause", {14'd0, state_o}, 16'd3);
    clr_cnt = 0;
    run_seen = 0;
    press(3'b101, 8);
    chk("b2b_clr_wins_idle", {14'd0, state_o}, 16'd0);
    chk("b2b_single_pulse", clr_cnt[15:0], 16'd1);
    chk("b2b_no_run", run_seen[15:0], 16'd0);
  endtask

  task automatic test_async_reset;
    press(3'b001, 8);
    din = 16'h0945;
    press(3'b010, 8);
    chk("ar_in_lap", {14'd0, state_o}, 16'd2);
    din = 16'h0951;
    #2 rst = 1'b1;
    #1;
    chk("ar_go_low", {15'd0, go}, 16'd0);
    chk("ar_state_idle", {14'd0, state_o}, 16'd0);
    chk("ar_disp_live", {d3, d2, d1, d0}, 16'h0951);
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic test_held_through_reset;
    rst = 1'b1;
    btn = 3'b001;
    cycles(3);
    rst = 1'b0;
    cycles(20);
    btn = '0;
    cycles(15);
    chk("held_reset_one_event", {14'd0, state_o}, 16'd1);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_lap();
    test_clear();
    test_back_to_back();
    test_async_reset();
    test_held_through_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
